clause_status_analyzer: RTL and testbench

- Parametrised, pipelined successor to the combinational BCP conflict check.
- Takes one clause per handshake (positive/negative literal masks) plus the current three-valued variable assignment.
- Classifies the clause as SAT, UNRESOLVED, UNIT (reporting the implied literal) or CONFLICT.
- Keeps a sticky conflict flag, the first conflicting clause id, and a conflict counter for the BCP controller.

---
 rtl/bcp_pkg.sv | 19 +
 rtl/clause_lit_eval.sv | 36 +++
 rtl/clause_status_analyzer.sv | 125 ++++++++++++
 tb/tb_clause_status_analyzer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_pkg.sv
// Shared types and sizing helpers for the BCP clause-status pipeline.
package bcp_pkg;

  typedef enum logic [1:0] {
    CS_SAT      = 2'b00,
    CS_UNRES    = 2'b01,
    CS_UNIT     = 2'b10,
    CS_CONFLICT = 2'b11
  } clause_status_e;

  localparam int VAR_NUM_DEF = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(VAR_NUM_DEF);

endpackage

// File: rtl/clause_lit_eval.sv
// Reduces registered true/free literal vectors to the facts the classifier needs.
module clause_lit_eval
  import bcp_pkg::*;
#(
  parameter int VAR_NUM = VAR_NUM_DEF,
  localparam int IW = idx_w(VAR_NUM)
) (
  input  logic [VAR_NUM-1:0] pos_true,
  input  logic [VAR_NUM-1:0] neg_true,
  input  logic [VAR_NUM-1:0] pos_free,
  input  logic [VAR_NUM-1:0] neg_free,
  output logic               any_true,
  output logic [1:0]         free_cnt,
  output logic [IW-1:0]      free_idx,
  output logic               free_pol
);

  always_comb begin
    any_true = (|pos_true) | (|neg_true);
    free_cnt = 2'd0;
    free_idx = '0;
    free_pol = 1'b0;
    // descending scan so the lowest free index is the one left standing
    for (int i = VAR_NUM - 1; i >= 0; i--) begin
      if (pos_free[i] | neg_free[i]) begin
        free_idx = IW'(i);
        free_pol = pos_free[i];
      end
    end
    for (int i = 0; i < VAR_NUM; i++) begin
      if (pos_free[i]) free_cnt = (free_cnt == 2'd2) ? 2'd2 : free_cnt + 2'd1;
      if (neg_free[i]) free_cnt = (free_cnt == 2'd2) ? 2'd2 : free_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/clause_status_analyzer.sv
// Two-stage clause classifier (SAT/UNRES/UNIT/CONFLICT) with sticky conflict tracking.
module clause_status_analyzer
  import bcp_pkg::*;
#(
  parameter int VAR_NUM = VAR_NUM_DEF,
  parameter int CID_W   = 8,
  parameter int CNT_W   = 16,
  localparam int IW = idx_w(VAR_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CID_W-1:0]   in_cid,
  input  logic [VAR_NUM-1:0] pos_mask,
  input  logic [VAR_NUM-1:0] neg_mask,
  input  logic [VAR_NUM-1:0] asg_def,
  input  logic [VAR_NUM-1:0] asg_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CID_W-1:0]   out_cid,
  output logic [1:0]         out_status,
  output logic [IW-1:0]      out_unit_idx,
  output logic               out_unit_pol,
  input  logic               clr_conflict,
  output logic               conflict,
  output logic [CID_W-1:0]   conflict_cid,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic [2:1]         vld_pipe;
  logic [VAR_NUM-1:0] pt, nt, pf, nf;
  logic [VAR_NUM-1:0] s1_pt, s1_nt, s1_pf, s1_nf;
  logic [CID_W-1:0]   s1_cid;
  logic               s1_load, s2_load, xfer_conf;
  logic               any_true, free_pol, unit_pol_nxt;
  logic [1:0]         free_cnt;
  logic [IW-1:0]      free_idx, unit_idx_nxt;
  clause_status_e     st_nxt;

  for (genvar i = 0; i < VAR_NUM; i++) begin : g_lit
    assign pt[i] = pos_mask[i] & asg_def[i] & asg_val[i];
    assign nt[i] = neg_mask[i] & asg_def[i] & ~asg_val[i];
    assign pf[i] = pos_mask[i] & ~asg_def[i];
    assign nf[i] = neg_mask[i] & ~asg_def[i];
  end

  assign s2_load   = ~vld_pipe[2] | out_ready;
  assign s1_load   = ~vld_pipe[1] | s2_load;
  assign in_ready  = rst_n & s1_load;
  assign out_valid = vld_pipe[2];
  assign xfer_conf = vld_pipe[2] & out_ready & (out_status == CS_CONFLICT);

  clause_lit_eval #(.VAR_NUM(VAR_NUM)) u_eval (
    .pos_true (s1_pt),
    .neg_true (s1_nt),
    .pos_free (s1_pf),
    .neg_free (s1_nf),
    .any_true (any_true),
    .free_cnt (free_cnt),
    .free_idx (free_idx),
    .free_pol (free_pol)
  );

  always_comb begin
    st_nxt       = CS_UNRES;
    unit_idx_nxt = '0;
    unit_pol_nxt = 1'b0;
    if (any_true)              st_nxt = CS_SAT;
    else if (free_cnt == 2'd0) st_nxt = CS_CONFLICT;
    else if (free_cnt == 2'd1) begin
      st_nxt       = CS_UNIT;
      unit_idx_nxt = free_idx;
      unit_pol_nxt = free_pol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s1_pt        <= '0;
      s1_nt        <= '0;
      s1_pf        <= '0;
      s1_nf        <= '0;
      s1_cid       <= '0;
      out_cid      <= '0;
      out_status   <= CS_SAT;
      out_unit_idx <= '0;
      out_unit_pol <= 1'b0;
      conflict     <= 1'b0;
      conflict_cid <= '0;
      conflict_cnt <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          s1_pt  <= pt;
          s1_nt  <= nt;
          s1_pf  <= pf;
          s1_nf  <= nf;
          s1_cid <= in_cid;
        end
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_cid      <= s1_cid;
          out_status   <= st_nxt;
          out_unit_idx <= unit_idx_nxt;
          out_unit_pol <= unit_pol_nxt;
        end
      end
      // a conflict leaving in the same cycle as a clear takes precedence
      if (xfer_conf) begin
        conflict <= 1'b1;
        if (!conflict || clr_conflict) conflict_cid <= out_cid;
        if (conflict_cnt != {CNT_W{1'b1}}) conflict_cnt <= conflict_cnt + CNT_W'(1);
      end else if (clr_conflict) begin
        conflict     <= 1'b0;
        conflict_cid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clause_status_analyzer.sv
// Randomized and directed bench for clause_status_analyzer with a queue-based reference model.
module tb_clause_status_analyzer;

  localparam int VN = 4;
  localparam int CW = 8;
  localparam int NW = 2;

  typedef struct {
    logic [CW-1:0] cid;
    logic [1:0]    st;
    logic [1:0]    idx;
    logic          pol;
    int            ready_at;
  } exp_t;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_cid, out_cid, conflict_cid;
  logic [VN-1:0] pos_mask, neg_mask, asg_def, asg_val;
  logic [1:0]    out_status, out_unit_idx;
  logic          out_unit_pol, clr_conflict, conflict;
  logic [NW-1:0] conflict_cnt;

  int   n_vec = 0, n_err = 0, n_out = 0, cyc = 0;
  exp_t sb[$];
  logic          m_conf = 1'b0;
  logic [CW-1:0] m_cid = '0;
  logic [NW-1:0] m_cnt = '0;

  clause_status_analyzer #(.VAR_NUM(VN), .CID_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cid(in_cid),
    .pos_mask(pos_mask), .neg_mask(neg_mask), .asg_def(asg_def), .asg_val(asg_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_cid(out_cid), .out_status(out_status),
    .out_unit_idx(out_unit_idx), .out_unit_pol(out_unit_pol), .clr_conflict(clr_conflict),
    .conflict(conflict), .conflict_cid(conflict_cid), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Classification straight from the literal rules: SAT > CONFLICT > UNIT > UNRES
  function automatic exp_t classify(input logic [CW-1:0] cid, input logic [VN-1:0] p, n, d, v);
    exp_t e;
    int nfree = 0;
    int fidx = -1;
    bit fpol = 0;
    bit sat = 0;
    for (int i = 0; i < VN; i++) begin
      if ((p[i] && d[i] && v[i]) || (n[i] && d[i] && !v[i])) sat = 1;
      if (p[i] && !d[i]) begin nfree++; if (fidx < 0) begin fidx = i; fpol = 1; end end
      if (n[i] && !d[i]) begin nfree++; if (fidx < 0) begin fidx = i; fpol = 0; end end
    end
    e.cid = cid; e.idx = 2'd0; e.pol = 1'b0; e.ready_at = 0;
    if (sat) e.st = 2'd0;
    else if (nfree == 0) e.st = 2'd3;
    else if (nfree == 1) begin e.st = 2'd2; e.idx = 2'(fidx); e.pol = fpol; end
    else e.st = 2'd1;
    return e;
  endfunction

  // Scoreboard: compares every cycle, then advances the model to the next edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v, exp_rdy;
    exp_v   = (sb.size() > 0) && (cyc >= sb[0].ready_at);
    exp_rdy = rst_n && ((sb.size() < 2) || out_ready);
    n_vec++;
    if (in_ready !== exp_rdy) begin n_err++; $display("FAIL mon_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_rdy); end
    n_vec++;
    if (out_valid !== exp_v) begin n_err++; $display("FAIL mon_out_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_v); end
    if (exp_v) begin
      n_vec++;
      if ({out_cid, out_status, out_unit_idx, out_unit_pol} !== {sb[0].cid, sb[0].st, sb[0].idx, sb[0].pol}) begin
        n_err++;
        $display("FAIL mon_result cyc=%0d got cid=%0d st=%0d idx=%0d pol=%b exp cid=%0d st=%0d idx=%0d pol=%b",
                 cyc, out_cid, out_status, out_unit_idx, out_unit_pol, sb[0].cid, sb[0].st, sb[0].idx, sb[0].pol);
      end
    end
    n_vec++;
    if ({conflict, conflict_cid, conflict_cnt} !== {m_conf, m_cid, m_cnt}) begin
      n_err++;
      $display("FAIL mon_sticky cyc=%0d got flag=%b cid=%0d cnt=%0d exp flag=%b cid=%0d cnt=%0d",
               cyc, conflict, conflict_cid, conflict_cnt, m_conf, m_cid, m_cnt);
    end
    if (!rst_n) begin
      sb.delete(); m_conf = 1'b0; m_cid = '0; m_cnt = '0;
    end else begin
      if (exp_v && out_ready) begin
        e = sb.pop_front();
        n_out++;
        if (e.st == 2'd3) begin
          if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
          if (!m_conf || clr_conflict) m_cid = e.cid;
          m_conf = 1'b1;
        end else if (clr_conflict) begin
          m_conf = 1'b0; m_cid = '0;
        end
      end else if (clr_conflict) begin
        m_conf = 1'b0; m_cid = '0;
      end
      if (in_valid && exp_rdy) begin
        e = classify(in_cid, pos_mask, neg_mask, asg_def, asg_val);
        e.ready_at = cyc + 2;
        sb.push_back(e);
      end
    end
    cyc++;
  end

  task automatic wait_edge();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [CW-1:0] cid, input logic [VN-1:0] p, n, d, v);
    bit acc = 0;
    in_valid = 1'b1; in_cid = cid; pos_mask = p; neg_mask = n; asg_def = d; asg_val = v;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk); acc = in_ready;
      wait_edge();
    end
    in_valid = 1'b0;
    n_vec++;
    if (!acc) begin n_err++; $display("FAIL send_timeout cid=%0d in_ready got 0 exp 1", cid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_conflict = 1'b0;
    in_cid = '0; pos_mask = '0; neg_mask = '0; asg_def = '0; asg_val = '0;
    repeat (2) wait_edge();
    n_vec++;
    if ({in_ready, out_valid, out_cid, out_status, out_unit_idx, out_unit_pol, conflict, conflict_cid, conflict_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_state got rdy=%b v=%b cid=%0d st=%0d idx=%0d pol=%b cf=%b ccid=%0d cnt=%0d exp all 0",
               in_ready, out_valid, out_cid, out_status, out_unit_idx, out_unit_pol, conflict, conflict_cid, conflict_cnt);
    end
    rst_n = 1'b1;
    wait_edge();
  endtask

  task automatic test_unit();
    send(8'd5, 4'b0101, 4'b0000, 4'b0011, 4'b0010);
    wait_edge();
    n_vec++;
    if ({out_valid, out_status, out_unit_idx, out_unit_pol, out_cid, conflict} !== {1'b1, 2'd2, 2'd2, 1'b1, 8'd5, 1'b0}) begin
      n_err++;
      $display("FAIL unit_basic got v=%b st=%0d idx=%0d pol=%b cid=%0d cf=%b exp v=1 st=2 idx=2 pol=1 cid=5 cf=0",
               out_valid, out_status, out_unit_idx, out_unit_pol, out_cid, conflict);
    end
    wait_edge();
  endtask

  task automatic chk_sticky(input string nm, input logic f, input logic [CW-1:0] c, input logic [NW-1:0] k);
    n_vec++;
    if ({conflict, conflict_cid, conflict_cnt} !== {f, c, k}) begin
      n_err++;
      $display("FAIL %s got flag=%b cid=%0d cnt=%0d exp flag=%b cid=%0d cnt=%0d", nm, conflict, conflict_cid, conflict_cnt, f, c, k);
    end
  endtask

  task automatic test_conflicts();
    send(8'd9, 4'b0011, 4'b0100, 4'b0111, 4'b0100);
    wait_edge();
    n_vec++;
    if ({out_valid, out_status, out_cid} !== {1'b1, 2'd3, 8'd9}) begin
      n_err++; $display("FAIL conflict_basic got v=%b st=%0d cid=%0d exp v=1 st=3 cid=9", out_valid, out_status, out_cid);
    end
    wait_edge();
    chk_sticky("conflict_first", 1'b1, 8'd9, 2'd1);
    send(8'd12, 4'b0011, 4'b0100, 4'b0111, 4'b0100);
    wait_edge(); wait_edge();
    chk_sticky("conflict_second", 1'b1, 8'd9, 2'd2);
    send(8'd14, 4'b0011, 4'b0100, 4'b0111, 4'b0100);
    wait_edge();
    clr_conflict = 1'b1;
    wait_edge();
    clr_conflict = 1'b0;
    chk_sticky("conflict_clr_race", 1'b1, 8'd14, 2'd3);
    clr_conflict = 1'b1;
    wait_edge();
    clr_conflict = 1'b0;
    chk_sticky("conflict_clear", 1'b0, 8'd0, 2'd3);
    send(8'd15, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_edge(); wait_edge();
    send(8'd16, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_edge(); wait_edge();
    chk_sticky("conflict_saturate", 1'b1, 8'd15, 2'd3);
  endtask

  task automatic test_edge_cases();
    logic [VN-1:0] tp[7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1001, 4'b1000, 4'b0110};
    logic [VN-1:0] tn[7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 4'b0010, 4'b0001};
    logic [VN-1:0] td[7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0101, 4'b1111};
    logic [VN-1:0] tv[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001};
    logic [1:0]    es[7] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd3};
    logic [1:0]    ei[7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
    logic          ep[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      send(8'(40 + i), tp[i], tn[i], td[i], tv[i]);
      wait_edge();
      n_vec++;
      if ({out_valid, out_status, out_unit_idx, out_unit_pol} !== {1'b1, es[i], ei[i], ep[i]}) begin
        n_err++;
        $display("FAIL edge_case_%0d got v=%b st=%0d idx=%0d pol=%b exp v=1 st=%0d idx=%0d pol=%b",
                 i, out_valid, out_status, out_unit_idx, out_unit_pol, es[i], ei[i], ep[i]);
      end
    end
    wait_edge();
  endtask

  task automatic test_backpressure();
    int j = 0;
    int base = n_out;
    for (int c = 0; c < 60; c++) begin
      out_ready = (c >= 5);
      in_valid = (j < 4); in_cid = 8'(20 + j);
      pos_mask = 4'b0011; neg_mask = 4'b0000; asg_def = 4'(j); asg_val = 4'b0000;
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        n_vec++;
        if ({j[2:0], in_ready, out_valid, out_cid} !== {3'd2, 1'b0, 1'b1, 8'd20}) begin
          n_err++;
          $display("FAIL bp_stall c=%0d got acc=%0d rdy=%b v=%b cid=%0d exp acc=2 rdy=0 v=1 cid=20", c, j, in_ready, out_valid, out_cid);
        end
      end
      if (in_valid && in_ready) j++;
      wait_edge();
      if (j == 4 && n_out - base == 4) break;
    end
    in_valid = 1'b0;
    n_vec++;
    if (n_out - base != 4 || j != 4) begin
      n_err++; $display("FAIL bp_drain got acc=%0d out=%0d exp acc=4 out=4", j, n_out - base);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(8'd50, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    send(8'd51, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    wait_edge();
    n_vec++;
    if ({out_valid, conflict, conflict_cnt, in_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_mid got v=%b cf=%b cnt=%0d rdy=%b exp all 0", out_valid, conflict, conflict_cnt, in_ready);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_edge();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_stale k=%0d got v=%b exp 0", k, out_valid); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_cid = 8'($urandom); pos_mask = 4'($urandom); neg_mask = 4'($urandom & $urandom);
      asg_def = 4'($urandom); asg_val = 4'($urandom);
      out_ready = (c < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      clr_conflict = ($urandom_range(0, 15) == 0);
      wait_edge();
    end
    in_valid = 1'b0; clr_conflict = 1'b0; out_ready = 1'b1;
    repeat (4) wait_edge();
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL random_drain got %0d pending exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_conflicts();
    test_edge_cases();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
